// File: rtl/item_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : item_select_ctrl
//  Description : Vending item selector. Picks the lowest-index selected item
//                that is still in stock, reports its price and runs a req/ack
//                vend handshake. Keeps one stock counter per item.
//  Revision    : 1.0 - initial release
// ============================================================================
module item_select_ctrl #(
    parameter int                          N_ITEMS     = 4,
    parameter int                          PRICE_W     = 4,
    parameter logic [N_ITEMS*PRICE_W-1:0]  ITEM_PRICES = 16'h1324,
    parameter int                          STOCK_W     = 4,
    parameter int                          STOCK_INIT  = 5,
    localparam int                         IDX_W       = ($clog2(N_ITEMS) > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_ITEMS-1:0]  sel_i,
    input  logic                confirm_i,
    input  logic                vend_ack_i,
    input  logic                restock_i,
    output logic [IDX_W-1:0]    item_idx_o,
    output logic [PRICE_W-1:0]  item_price_o,
    output logic                price_valid_o,
    output logic                vend_req_o,
    output logic                vend_done_o,
    output logic [N_ITEMS-1:0]  sold_out_o
);

    localparam logic [STOCK_W-1:0] C_STOCK_INIT = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] C_STOCK_ONE  = STOCK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_VENDING  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PRICE_W-1:0]   price_q, price_d;
    logic                 pv_q, pv_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;
    logic [STOCK_W-1:0]   stock_q [N_ITEMS];
    logic [STOCK_W-1:0]   stock_d [N_ITEMS];
    logic [N_ITEMS-1:0]   sold_out_q, sold_out_d;

    logic [N_ITEMS-1:0]   w_ereq;
    logic                 w_any;
    logic [IDX_W-1:0]     w_win;
    logic [PRICE_W-1:0]   w_win_price;
    logic                 w_dec;
    logic [PRICE_W-1:0]   w_price_tbl [N_ITEMS];

    // Unpack the flat price parameter into a per-item table.
    generate
        for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price
            assign w_price_tbl[gi] = ITEM_PRICES[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    // Mask sold-out items and find the lowest-index remaining request.
    always_comb begin
        w_ereq = sel_i & ~sold_out_q;
        w_any  = |w_ereq;
        w_win  = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (w_ereq[i]) begin
                w_win = IDX_W'(i);
            end
        end
        w_win_price = w_price_tbl[w_win];
    end

    // Next-state and registered-output values of the selection/vend FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        price_d = price_q;
        pv_d    = pv_q;
        req_d   = req_q;
        done_d  = 1'b0;
        w_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    idx_d   = w_win;
                    price_d = w_win_price;
                    pv_d    = 1'b1;
                    state_d = ST_SELECTED;
                end
            end
            ST_SELECTED: begin
                // A cancel outranks a coincident confirm; a confirm vends the
                // item already latched even if the winner moved this cycle.
                if (!w_any) begin
                    pv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (confirm_i) begin
                    req_d   = 1'b1;
                    state_d = ST_VENDING;
                end else if (w_win != idx_q) begin
                    idx_d   = w_win;
                    price_d = w_win_price;
                end
            end
            ST_VENDING: begin
                if (vend_ack_i) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    pv_d    = 1'b0;
                    w_dec   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Raw switches must all open before a new selection is taken.
                if (sel_i == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stock update: saturating decrement on a completed vend, restock overrides.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (w_dec && (IDX_W'(i) == idx_q) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - C_STOCK_ONE;
            end
            if (restock_i) begin
                stock_d[i] = C_STOCK_INIT;
            end
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            price_q <= '0;
            pv_q    <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            price_q <= price_d;
            pv_q    <= pv_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    // Stock counters and the registered sold-out mask.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= C_STOCK_INIT;
            end
            sold_out_q <= {N_ITEMS{C_STOCK_INIT == '0}};
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
            sold_out_q <= sold_out_d;
        end
    end

    assign item_idx_o    = idx_q;
    assign item_price_o  = price_q;
    assign price_valid_o = pv_q;
    assign vend_req_o    = req_q;
    assign vend_done_o   = done_q;
    assign sold_out_o    = sold_out_q;

endmodule
`default_nettype wire

// File: tb/tb_item_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_item_select_ctrl
//  Description : Self-checking bench for item_select_ctrl with a behavioural
//                reference model of the vending selector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_item_select_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  sel_i;
    logic        confirm_i;
    logic        vend_ack_i;
    logic        restock_i;
    logic [1:0]  item_idx_o;
    logic [3:0]  item_price_o;
    logic        price_valid_o;
    logic        vend_req_o;
    logic        vend_done_o;
    logic [3:0]  sold_out_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain integers describing what the buyer would see.
    int prices [4] = '{4, 2, 3, 1};
    int m_stock [4];
    int m_phase;          // 0 idle, 1 item chosen, 2 dispensing, 3 waiting for switches off
    int m_idx, m_price;
    bit m_pv, m_req, m_done;

    item_select_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sel_i         (sel_i),
        .confirm_i     (confirm_i),
        .vend_ack_i    (vend_ack_i),
        .restock_i     (restock_i),
        .item_idx_o    (item_idx_o),
        .item_price_o  (item_price_o),
        .price_valid_o (price_valid_o),
        .vend_req_o    (vend_req_o),
        .vend_done_o   (vend_done_o),
        .sold_out_o    (sold_out_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] model_sold();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (m_stock[i] == 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
        m_phase = 0; m_idx = 0; m_price = 0;
        m_pv = 0; m_req = 0; m_done = 0;
    endtask

    // Advance the model by one clock given the inputs present before the edge.
    task automatic model_step(input logic [3:0] s, input bit c, input bit a, input bit r);
        logic [3:0] avail;
        int first;
        avail = s & ~model_sold();
        first = -1;
        for (int i = 3; i >= 0; i--) if (avail[i]) first = i;
        m_done = 0;
        if (m_phase == 0) begin
            if (first >= 0) begin
                m_idx = first; m_price = prices[first]; m_pv = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (first < 0) begin
                m_pv = 0; m_phase = 0;
            end else if (c) begin
                m_req = 1; m_phase = 2;
            end else if (first != m_idx) begin
                m_idx = first; m_price = prices[first];
            end
        end else if (m_phase == 2) begin
            if (a) begin
                m_req = 0; m_done = 1; m_pv = 0; m_phase = 3;
                if (m_stock[m_idx] > 0) m_stock[m_idx] = m_stock[m_idx] - 1;
            end
        end else begin
            if (s == 4'b0000) m_phase = 0;
        end
        if (r) for (int i = 0; i < 4; i++) m_stock[i] = 5;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("item_idx",    32'(item_idx_o),    32'(m_idx));
        chk("item_price",  32'(item_price_o),  32'(m_price));
        chk("price_valid", 32'(price_valid_o), 32'(m_pv));
        chk("vend_req",    32'(vend_req_o),    32'(m_req));
        chk("vend_done",   32'(vend_done_o),   32'(m_done));
        chk("sold_out",    32'(sold_out_o),    32'(model_sold()));
    endtask

    // Apply inputs for one cycle, clock, then compare against the model.
    task automatic step(input logic [3:0] s, input bit c, input bit a, input bit r);
        sel_i = s; confirm_i = c; vend_ack_i = a; restock_i = r;
        model_step(s, c, a, r);
        @(posedge clk_i);
        #1;
        confirm_i = 0; vend_ack_i = 0; restock_i = 0;
        check_all();
    endtask

    // Select, confirm and complete one vend of a single item, then release.
    task automatic vend_once(input logic [3:0] s);
        step(s, 0, 0, 0);
        step(s, 1, 0, 0);
        step(s, 0, 1, 0);
        step(4'b0000, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1; sel_i = 0; confirm_i = 0; vend_ack_i = 0; restock_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all();
        rst_i = 0;

        // Basic selection and relatch to a lower index.
        step(4'b0100, 0, 0, 0);
        chk("sel2_idx", 32'(item_idx_o), 2);
        chk("sel2_price", 32'(item_price_o), 3);
        step(4'b0110, 0, 0, 0);
        chk("relatch_idx", 32'(item_idx_o), 1);
        chk("relatch_price", 32'(item_price_o), 2);

        // Vend item0 with a slow acknowledge and a held switch afterwards.
        step(4'b0001, 0, 0, 0);
        step(4'b0001, 1, 0, 0);
        chk("req_after_confirm", 32'(vend_req_o), 1);
        repeat (3) step(4'b0001, 0, 0, 0);
        chk("req_held", 32'(vend_req_o), 1);
        step(4'b0001, 0, 1, 0);
        chk("done_pulse", 32'(vend_done_o), 1);
        step(4'b0001, 0, 0, 0);
        chk("done_single", 32'(vend_done_o), 0);
        step(4'b0001, 0, 1, 0);
        chk("held_no_pv", 32'(price_valid_o), 0);
        step(4'b0000, 0, 0, 0);
        step(4'b0001, 0, 0, 0);
        chk("reselect_pv", 32'(price_valid_o), 1);

        // Drain item3 to sold out.
        step(4'b0000, 0, 0, 0);
        repeat (5) vend_once(4'b1000);
        chk("item3_soldout", 32'(sold_out_o), 32'h8);
        step(4'b1000, 0, 0, 0);
        chk("soldout_masked", 32'(price_valid_o), 0);
        step(4'b1001, 0, 0, 0);
        chk("fallback_idx", 32'(item_idx_o), 0);
        chk("fallback_price", 32'(item_price_o), 4);

        // Cancel coincident with confirm.
        step(4'b0000, 1, 0, 0);
        chk("cancel_pv", 32'(price_valid_o), 0);
        step(4'b0000, 0, 0, 0);
        chk("cancel_no_req", 32'(vend_req_o), 0);

        // Bring item1 to stock 1, then restock on the same edge as the ack.
        repeat (4) vend_once(4'b0010);
        step(4'b0010, 0, 0, 0);
        step(4'b0010, 1, 0, 0);
        step(4'b0010, 0, 1, 1);
        chk("restock_done", 32'(vend_done_o), 1);
        chk("restock_soldout", 32'(sold_out_o), 0);
        step(4'b0000, 0, 0, 0);

        // Asynchronous reset while a vend request is outstanding.
        step(4'b0100, 0, 0, 0);
        step(4'b0100, 1, 0, 0);
        chk("pre_reset_req", 32'(vend_req_o), 1);
        #2 rst_i = 1;
        #1;
        model_reset();
        chk("async_req", 32'(vend_req_o), 0);
        chk("async_pv", 32'(price_valid_o), 0);
        chk("async_price", 32'(item_price_o), 0);
        chk("async_idx", 32'(item_idx_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 0; sel_i = 0;
        check_all();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s = 4'b0000;
            step(s, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/item_select_ctrl.md
Name: item_select_ctrl

Overview:
- Parametrised vending item selector with a selection/vend state machine.
- Resolves N item-select switches to one latched item using fixed priority, lowest index wins.
- Reports the item's price from a parameter table and tracks per-item stock with sold-out masking.
- Runs a req/ack vend handshake with the dispenser, between the switch inputs and the payment/dispense logic.

Parameters:
- N_ITEMS, 4, number of item-select switches/items (min 2).
- PRICE_W, 4, width of each price entry and of ITEM_PRICE.
- ITEM_PRICES, 16'h1324, packed N_ITEMS*PRICE_W price table; bits [i*PRICE_W +: PRICE_W] are the price of item i. Default is item0=4, item1=2, item2=3, item3=1.
- STOCK_W, 4, width of each per-item stock counter.
- STOCK_INIT, 5, stock loaded into every counter on reset and on RESTOCK (must fit STOCK_W).
- localparam IDX_W = max(1, $clog2(N_ITEMS)).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SEL  in  N_ITEMS  item-select switches (already debounced/synchronised); bit i requests item i.
- CONFIRM  in  1  one-cycle pulse: buyer/payment logic commits the current selection.
- VEND_ACK  in  1  dispenser acknowledge of VEND_REQ.
- RESTOCK  in  1  one-cycle pulse: reload all stock counters to STOCK_INIT.
- ITEM_IDX  out  IDX_W  index of latched item.
- ITEM_PRICE  out  PRICE_W  price of latched item.
- PRICE_VALID  out  1  ITEM_IDX/ITEM_PRICE are meaningful.
- VEND_REQ  out  1  vend request to dispenser.
- VEND_DONE  out  1  one-cycle pulse when a vend completes.
- SOLD_OUT  out  N_ITEMS  bit i high when stock[i]==0.

Behaviour:
- Reset (async, RST=1):
  - State IDLE; ITEM_IDX=0, ITEM_PRICE=0, PRICE_VALID=0, VEND_REQ=0, VEND_DONE=0.
  - All stock counters = STOCK_INIT; SOLD_OUT = all ones if STOCK_INIT==0, else 0.
  - Reset mid-vend drops VEND_REQ immediately with no stock decrement.
- Masking and priority:
  - Effective request EREQ = SEL & ~SOLD_OUT.
  - Winner W = lowest set index of EREQ.
  - All outputs are registered.
- IDLE:
  - If EREQ!=0: latch ITEM_IDX=W, ITEM_PRICE=ITEM_PRICES[W]; next state SELECTED.
  - PRICE_VALID goes high on the same edge, one cycle after SEL rises.
- SELECTED (PRICE_VALID=1). Per cycle, in priority order:
  1. EREQ==0 → IDLE, PRICE_VALID=0 next cycle. This is a cancel and ignores a coincident CONFIRM.
  2. CONFIRM=1 → VENDING with the currently latched item; a changed W is not applied that cycle. VEND_REQ=1 next cycle.
  3. W != ITEM_IDX → relatch ITEM_IDX/ITEM_PRICE to W, staying in SELECTED.
- VENDING:
  - VEND_REQ held high, ITEM_IDX/ITEM_PRICE frozen, SEL ignored.
  - VEND_ACK=1 → VEND_REQ=0, VEND_DONE=1 for exactly one cycle, stock[ITEM_IDX] decrements by 1 (saturating at 0), next state RELEASE.
  - VEND_ACK while not in VENDING is ignored.
- RELEASE:
  - PRICE_VALID=0.
  - Wait for SEL==0 (raw SEL, not EREQ), then IDLE. This prevents a repeat vend from a held switch.
- RESTOCK:
  - Any state: every counter = STOCK_INIT next cycle; SOLD_OUT updates on the same edge.
  - If coincident with the VEND_ACK decrement, RESTOCK wins (counter = STOCK_INIT).
  - State transitions are unaffected.
- Sold-out:
  - SOLD_OUT[i] is registered and reflects the counter after the update.
  - An item reaching 0 while held in RELEASE has no effect until the next selection.

Test Plan:
- Default params, reset, SEL=4'b0100 → PRICE_VALID=1, ITEM_IDX=2, ITEM_PRICE=3 one cycle later; SEL=4'b0110 → relatch ITEM_IDX=1, ITEM_PRICE=2.
- SELECTED on item0; CONFIRM pulse → VEND_REQ=1 next cycle and held across 3 idle cycles; VEND_ACK → VEND_DONE single pulse, stock0 goes 5→4, state RELEASE; SEL held high gives no new PRICE_VALID until SEL=0 then SEL=1.
- Vend item3 five times → SOLD_OUT=4'b1000; SEL=4'b1000 → PRICE_VALID stays 0; SEL=4'b1001 → ITEM_IDX=0, ITEM_PRICE=4.
- In SELECTED, SEL→0 in the same cycle as CONFIRM → IDLE, VEND_REQ never asserts, stock unchanged.
- RESTOCK in the same cycle as VEND_ACK for an item with stock 1 → stock=5, SOLD_OUT bit stays 0, VEND_DONE still pulses.
- RST asserted asynchronously while VEND_REQ=1 → VEND_REQ, PRICE_VALID, ITEM_PRICE drop to 0 without waiting for a clock edge; all stock=5.
